// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads a 1-cycle synchronous imem, buffers {pc,instr} in a DEPTH-entry FIFO.
// Latency: first fetch valid 2 cycles after issue, redirect target valid 3 cycles after redirect.
// Backpressure: issue stalls while buffered + in-flight reaches DEPTH. Macro FETCH_MISALIGN_TRAP_EN enables the misalign trap.

module fetch_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [DW-1:0]          push_dat_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          head_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = cnt_q;
endmodule

module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             fault
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
    localparam logic [0:0] ST_RUN  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [0:0] ST_HALT = 1'b1;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [31:0]      ins;
    } entry_t;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;
    logic [0:0]       state_q, state_d;

    logic             running;
    logic             push, pop;
    logic [CW-1:0]    fifo_cnt;
    logic [CW-1:0]    occ;
    entry_t           push_ent, head_ent;

    // Held-in-reset outputs are forced quiet regardless of stale state.
    assign running     = !rst && (state_q == ST_RUN);
    assign occ         = fifo_cnt + CW'(inflight_q);
    assign imem_req    = running && !redirect && (occ < CW'(DEPTH));
    assign imem_addr   = pc_q;
    assign instr_valid = running && (fifo_cnt != '0);
    assign pop         = instr_valid && instr_ready;
    assign push        = inflight_q && !redirect;
    assign push_ent    = '{pc: req_pc_q, ins: imem_rdata};
    assign instr       = head_ent.ins;
    assign instr_pc    = head_ent.pc;

    fetch_fifo #(
        .DW    ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (redirect),
        .push_i     (push),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .head_dat_o (head_ent),
        .count_o    (fifo_cnt)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    logic misalign;
    assign misalign = |redirect_pc[1:0];
    assign fault    = fault_q;
`else
    assign fault    = 1'b0;
`endif

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        state_d    = state_q;
        inflight_d = imem_req;
        if (imem_req) begin
            pc_d     = pc_q + WIDTH'(4);
            req_pc_d = pc_q;
        end
        if (redirect && state_q == ST_RUN) pc_d = redirect_pc & ALIGN_MASK;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d = fault_q;
        if (redirect && state_q == ST_RUN && misalign) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            state_q    <= ST_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            state_q    <= state_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q    <= fault_d;
`endif
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a 32-bit instance with RESET_PC=0 and an 8-bit instance with RESET_PC=F8.
module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, redir0, req0, vld0, rdy0, flt0;
    logic [31:0] rpc0, addr0, rdata0, ins0, ipc0;
    logic        rst1, redir1, req1, vld1, rdy1, flt1;
    logic [7:0]  rpc1, addr1, ipc1;
    logic [31:0] rdata1, ins1;

    fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) u0 (
        .clk(clk), .rst(rst0), .redirect(redir0), .redirect_pc(rpc0),
        .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
        .instr_valid(vld0), .instr_ready(rdy0), .instr(ins0), .instr_pc(ipc0), .fault(flt0)
    );

    fetch_unit #(.WIDTH(8), .DEPTH(4), .RESET_PC(8'hF8)) u1 (
        .clk(clk), .rst(rst1), .redirect(redir1), .redirect_pc(rpc1),
        .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
        .instr_valid(vld1), .instr_ready(rdy1), .instr(ins1), .instr_pc(ipc1), .fault(flt1)
    );

    function automatic logic [31:0] f32(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] f8(input logic [7:0] a);
        return {24'hC0FFEE, a};
    endfunction

    // Synchronous instruction memories: data for address of cycle n appears in cycle n+1.
    always @(posedge clk) begin
        rdata0 <= f32(addr0);
        rdata1 <= f8(addr1);
    end

    int checks = 0;
    int errors = 0;
    int nreq0  = 0;

    logic [31:0] q0[$];
    logic [7:0]  q1[$];
    logic [31:0] nxt0;
    logic [7:0]  nxt1;
    logic        halt0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        logic [31:0] e;
        logic [7:0]  e8;
        @(negedge clk);
        if (rst0) begin
            chk("rst0_req", 32'(req0), 32'd0);
            chk("rst0_vld", 32'(vld0), 32'd0);
            q0.delete();
            nxt0  = 32'h0;
            halt0 = 1'b0;
        end else begin
            if (req0) nreq0++;
            chk("fault0", 32'(flt0), 32'(halt0));
            if (halt0) begin
                chk("halt_req", 32'(req0), 32'd0);
                chk("halt_vld", 32'(vld0), 32'd0);
            end else begin
                if (vld0 && rdy0) begin
                    if (q0.size() == 0) begin
                        chk("sb0_nonempty", 32'(q0.size()), 32'd1);
                    end else begin
                        e = q0.pop_front();
                        chk("sb0_pc", ipc0, e);
                        chk("sb0_instr", ins0, f32(e));
                    end
                end
                if (redir0) begin
                    chk("redir_noreq", 32'(req0), 32'd0);
                    q0.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (rpc0[1:0] != 2'b00) halt0 = 1'b1;
`endif
                    nxt0 = {rpc0[31:2], 2'b00};
                end else if (req0) begin
                    chk("sb0_addr", addr0, nxt0);
                    q0.push_back(nxt0);
                    nxt0 = nxt0 + 32'd4;
                end
            end
        end
        if (rst1) begin
            chk("rst1_req", 32'(req1), 32'd0);
            chk("rst1_vld", 32'(vld1), 32'd0);
            q1.delete();
            nxt1 = 8'hF8;
        end else begin
            chk("fault1", 32'(flt1), 32'd0);
            if (vld1 && rdy1) begin
                if (q1.size() == 0) begin
                    chk("sb1_nonempty", 32'(q1.size()), 32'd1);
                end else begin
                    e8 = q1.pop_front();
                    chk("sb1_pc", 32'(ipc1), 32'(e8));
                    chk("sb1_instr", ins1, f8(e8));
                end
            end
            if (req1) begin
                chk("sb1_addr", 32'(addr1), 32'(nxt1));
                q1.push_back(nxt1);
                nxt1 = nxt1 + 8'd4;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    initial begin
        logic [7:0] e8;
        rst0 = 1'b1; redir0 = 1'b0; rpc0 = 32'h0; rdy0 = 1'b1;
        rst1 = 1'b1; redir1 = 1'b0; rpc1 = 8'h0;  rdy1 = 1'b1;
        adv();
        cyc();
        cyc();

        // Reset release: addresses 0,4,8 and first valid in cycle 2
        rst0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("t1_req", 32'(req0), 32'd1);
            chk("t1_addr", addr0, 32'(c * 4));
            chk("t1_vld", 32'(vld0), 32'(c == 2));
            if (c == 2) chk("t1_pc", ipc0, 32'h0);
            adv();
        end
        repeat (5) cyc();

        // Stalled decode: exactly DEPTH requests, stable head
        rst0 = 1'b1;
        cyc();
        rst0 = 1'b0; rdy0 = 1'b0; nreq0 = 0;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (c >= 2) begin
                chk("t2_vld", 32'(vld0), 32'd1);
                chk("t2_head", ipc0, 32'h0);
            end
            adv();
        end
        chk("t2_nreq", 32'(nreq0), 32'd4);
        rdy0 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sample();
            chk("t2_order", ipc0, 32'(c * 4));
            adv();
        end

        // Redirect while the FIFO is full
        rdy0 = 1'b0;
        repeat (7) cyc();
        sample();
        chk("t3_full_vld", 32'(vld0), 32'd1);
        chk("t3_full_noreq", 32'(req0), 32'd0);
        adv();
        redir0 = 1'b1; rpc0 = 32'h100; rdy0 = 1'b1;
        cyc();
        redir0 = 1'b0;
        sample();
        chk("t3_r1_req", 32'(req0), 32'd1);
        chk("t3_r1_addr", addr0, 32'h100);
        chk("t3_r1_vld", 32'(vld0), 32'd0);
        adv();
        sample();
        chk("t3_r2_vld", 32'(vld0), 32'd0);
        adv();
        sample();
        chk("t3_r3_vld", 32'(vld0), 32'd1);
        chk("t3_r3_pc", ipc0, 32'h100);
        adv();
        repeat (4) cyc();

        // Back-to-back redirects: the second wins
        redir0 = 1'b1; rpc0 = 32'h200;
        cyc();
        rpc0 = 32'h300;
        cyc();
        redir0 = 1'b0;
        sample();
        chk("t4_addr", addr0, 32'h300);
        chk("t4_req", 32'(req0), 32'd1);
        adv();
        cyc();
        sample();
        chk("t4_vld", 32'(vld0), 32'd1);
        chk("t4_pc", ipc0, 32'h300);
        adv();
        repeat (4) cyc();

        // Misaligned redirect
        redir0 = 1'b1; rpc0 = 32'h102;
        cyc();
        redir0 = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int c = 0; c < 6; c++) begin
            sample();
            chk("t6_fault", 32'(flt0), 32'd1);
            chk("t6_noreq", 32'(req0), 32'd0);
            chk("t6_novld", 32'(vld0), 32'd0);
            adv();
        end
        rst0 = 1'b1;
        cyc();
        rst0 = 1'b0;
        sample();
        chk("t6_rst_fault", 32'(flt0), 32'd0);
        chk("t6_rst_req", 32'(req0), 32'd1);
        chk("t6_rst_addr", addr0, 32'h0);
        adv();
`else
        sample();
        chk("t6_req", 32'(req0), 32'd1);
        chk("t6_addr", addr0, 32'h100);
        chk("t6_fault", 32'(flt0), 32'd0);
        adv();
        cyc();
        sample();
        chk("t6_vld", 32'(vld0), 32'd1);
        chk("t6_pc", ipc0, 32'h100);
        chk("t6_fault_late", 32'(flt0), 32'd0);
        adv();
`endif
        repeat (3) cyc();

        // 8-bit PC wrap and mid-stream reset
        rst1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sample();
            e8 = 8'hF8 + 8'(c * 4);
            chk("t5_req", 32'(req1), 32'd1);
            chk("t5_addr", 32'(addr1), 32'(e8));
            adv();
        end
        repeat (3) cyc();
        rst1 = 1'b1;
        sample();
        chk("t5_inrst_vld", 32'(vld1), 32'd0);
        chk("t5_inrst_req", 32'(req1), 32'd0);
        adv();
        rst1 = 1'b0;
        sample();
        chk("t5_post_vld", 32'(vld1), 32'd0);
        chk("t5_post_req", 32'(req1), 32'd1);
        chk("t5_post_addr", 32'(addr1), 32'h0000_00F8);
        adv();
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
